data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Load/store sequencer between the pipeline memory stage and the word-addressed 1024 x 32 data memory.
- Accepts one byte-addressed RISC-V load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives the memory's read/write enables and word address.
- Sub-word stores are done as read-modify-write; load data is sign- or zero-extended.
- Misaligned or illegal accesses get an error response with no memory access.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory.
- WADDR_WIDTH, 10, width of the word index driven to memory; must be at least clog2(MEM_WORDS).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 access size/sign.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_error  output  1  valid with resp_valid; misaligned, illegal funct3 or out-of-range.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- mem_read_enable  output  1  to memory.
- mem_write_enable  output  1  to memory.
- mem_address  output  32  word index, zero-extended from WADDR_WIDTH bits.
- mem_write_data  output  32  full word to write.
- mem_read_data  input  32  combinational read data from memory.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0 except req_ready=1. Latched request cleared.
- Reset mid-operation aborts the access. Any pending RMW write is dropped and no response is issued.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. At acceptance the controller latches write, funct3, addr[1:0], word index = addr[WADDR_WIDTH+1:2], and wdata.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values are illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- States and transitions:
  - IDLE: on acceptance go to ERR if the request is illegal or misaligned; else LOAD for loads, WR for SW, RMW_RD for SB/SH.
  - LOAD: mem_read_enable=1, mem_address=index. Capture mem_read_data at the edge, extract the lane from addr[1:0], extend. Go to RESP.
  - RMW_RD: mem_read_enable=1. Capture the word at the edge. Go to RMW_WR.
  - RMW_WR: mem_write_enable=1. mem_write_data = captured word with byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) replaced by the low bits of wdata. Go to RESP.
  - WR: mem_write_enable=1, mem_write_data=wdata. Go to RESP.
  - ERR: no enables asserted. Go to RESP with the error flag set.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Latency from the acceptance edge to the resp_valid cycle: load 2, SW 2, SB/SH 3, error 2.
- Enables are never asserted together. Outside LOAD/RMW_RD/RMW_WR/WR, mem_address and mem_write_data are 0.
- Lane extraction: byte lane = addr[1:0]*8, halfword lane = addr[1]*16. LB/LH sign-extend; LBU/LHU zero-extend.
- resp_rdata and resp_error hold their values only during the RESP cycle and are 0 otherwise.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: a request whose addr[31:2] >= MEM_WORDS goes to ERR (resp_error=1, no memory access).
- Undefined: upper address bits are ignored and the word index wraps modulo 2^WADDR_WIDTH. Example: byte address 0x1004 maps to word 1.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: req_ready=1, all other outputs 0. Then SW addr=0x10 wdata=0xDEADBEEF. Required: one write to word 4 with data 0xDEADBEEF; resp_valid 2 cycles after acceptance; resp_error=0.
- Sub-word store: memory word 4 = 0xDEADBEEF, SB addr=0x12 wdata=0x000000AA. Required: RMW_RD then RMW_WR writes 0xDEAABEEF; resp_valid 3 cycles after acceptance; no read and write enable in the same cycle.
- Sign handling: memory word 4 = 0xDEAABEEF. LB addr=0x13 → resp_rdata=0xFFFFFFDE. LBU addr=0x13 → 0x000000DE. LH addr=0x10 → 0xFFFFBEEF. LHU addr=0x12 → 0x0000DEAA.
- Error cases: LW addr=0x11, SH addr=0x13, and load funct3=011. Required for each: no memory enable ever asserted; resp_valid with resp_error=1 and resp_rdata=0, 2 cycles after acceptance.
- Reset mid-RMW: issue SH addr=0x20, then assert reset during RMW_RD. Required: no write to word 8, no resp_valid, IDLE with req_ready=1 after release.
- Bounds (both builds): LW addr=0x1004. With DMEM_BOUNDS_CHECK_EN: resp_error=1. Without: reads word 1 and resp_error=0.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl
// Load/store sequencer between the pipeline memory stage and a word-addressed
// 32-bit data memory. One byte-addressed RISC-V load/store is in flight at a time.
// Sub-word stores are read-modify-write. Load data is sign- or zero-extended.
// Misaligned or illegal requests get an error response and touch no memory.
//
// Optional feature (compile-time macro DMEM_BOUNDS_CHECK_EN):
//   defined   - a request with addr[31:2] >= MEM_WORDS takes the error path.
//   undefined - upper address bits are ignored and the word index wraps
//               modulo 2^WADDR_WIDTH.
module data_mem_access_ctrl #(
    parameter int MEM_WORDS   = 1024,
    parameter int WADDR_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WR     = 3'd4,
        ST_ERR    = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state_reg;
    state_t state_next;

    // Request fields latched at acceptance
    logic [2:0]             funct3_reg;
    logic [1:0]             lane_reg;
    logic [WADDR_WIDTH-1:0] index_reg;
    logic [31:0]            wdata_reg;
    logic                   err_reg;

    // Word captured during the read half of a read-modify-write
    logic [31:0]            word_reg;
    // Extended load result presented during the response cycle
    logic [31:0]            rdata_reg;

    logic                   accept;
    logic                   funct3_legal;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   req_bad;
    logic [31:0]            load_ext;
    logic [3:0][7:0]        merged_word;
    logic [31:0]            index_ext;

    assign accept    = req_valid && req_ready;
    assign index_ext = 32'(index_reg);

    // Classify the incoming request: legal encoding, natural alignment, range
    always_comb begin
        funct3_legal = 1'b0;
        misaligned   = 1'b0;
        if (req_write) begin
            funct3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                           (req_funct3 == F3_W);
        end else begin
            funct3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                           (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                           (req_funct3 == F3_HU);
        end
        // Size lives in funct3[1:0]; only halfword and word need alignment
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
        req_bad = !funct3_legal || misaligned || out_of_range;
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    // Any word index beyond the populated memory is rejected
    assign out_of_range = (32'(req_addr[31:2]) >= 32'(MEM_WORDS));
`else
    // Upper address bits are deliberately ignored; the index wraps
    logic unused_addr_bits;
    assign out_of_range     = 1'b0;
    assign unused_addr_bits = ^req_addr[31:WADDR_WIDTH+2];
`endif

    // Select the addressed lane of the returned word and extend it to 32 bits
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte = mem_read_data[{lane_reg, 3'b000} +: 8];
        lane_half = mem_read_data[{lane_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            F3_B:    load_ext = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    load_ext = {{16{lane_half[15]}}, lane_half};
            F3_BU:   load_ext = {24'h000000, lane_byte};
            F3_HU:   load_ext = {16'h0000, lane_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Byte-wise merge of store data into the captured word for SB/SH
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            logic       byte_hit;
            logic [7:0] byte_src;
            // SB replaces exactly one lane; SH replaces the lane pair picked by addr[1]
            assign byte_hit = (funct3_reg == F3_B) ? (lane_reg == 2'(gi))
                                                   : (lane_reg[1] == 1'(gi >> 1));
            // Odd bytes of a halfword store come from wdata[15:8]
            assign byte_src = ((gi % 2 == 1) && (funct3_reg == F3_H)) ? wdata_reg[15:8]
                                                                      : wdata_reg[7:0];
            assign merged_word[gi] = byte_hit ? byte_src : word_reg[gi*8 +: 8];
        end
    endgenerate

    // State register; reset aborts whatever access is in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, RMW capture and load-result register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            funct3_reg <= 3'b000;
            lane_reg   <= 2'b00;
            index_reg  <= '0;
            wdata_reg  <= 32'h0;
            err_reg    <= 1'b0;
            word_reg   <= 32'h0;
            rdata_reg  <= 32'h0;
        end else begin
            if (accept) begin
                funct3_reg <= req_funct3;
                lane_reg   <= req_addr[1:0];
                index_reg  <= req_addr[WADDR_WIDTH+1:2];
                wdata_reg  <= req_wdata;
                err_reg    <= req_bad;
                rdata_reg  <= 32'h0;
            end
            if (state_reg == ST_LOAD) begin
                rdata_reg <= load_ext;
            end
            if (state_reg == ST_RMW_RD) begin
                word_reg <= mem_read_data;
            end
        end
    end

    // Next-state and output decode; every output defaults to its idle value
    always_comb begin
        state_next       = state_reg;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        resp_rdata       = 32'h0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_next = ST_ERR;
                    end else if (!req_write) begin
                        state_next = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_read_enable = 1'b1;
                mem_address     = index_ext;
                state_next      = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read_enable = 1'b1;
                mem_address     = index_ext;
                state_next      = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write_enable = 1'b1;
                mem_address      = index_ext;
                mem_write_data   = merged_word;
                state_next       = ST_RESP;
            end
            ST_WR: begin
                mem_write_enable = 1'b1;
                mem_address      = index_ext;
                mem_write_data   = wdata_reg;
                state_next       = ST_RESP;
            end
            ST_ERR: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_reg;
                resp_rdata = rdata_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Testbench for data_mem_access_ctrl: directed scenarios followed by random
// load/store traffic, compared against a word-array reference model.
module tb_data_mem_access_ctrl;

    localparam int MW = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];
    bit          mem_init_done = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_access_ctrl #(.MEM_WORDS(1024), .WADDR_WIDTH(10)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_error       (resp_error),
        .resp_rdata       (resp_rdata),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory behind the DUT: combinational read, write on the rising edge
    assign mem_read_data = mem[mem_address[9:0]];
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MW; i++) mem[i] <= word_pat(i);
            mem_init_done <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: expected outcome of one request from the ISA rules
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output bit err, output logic [31:0] rdata,
                         output int lat, output int n_rd, output int n_wr,
                         output int idx, output logic [31:0] new_word);
        int          size;
        bit          legal;
        int          sh;
        logic [31:0] w;
        logic [31:0] v;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << int'(f3[1:0]);
        err   = !legal || ((addr % 32'(size)) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        if ((addr >> 2) >= 32'(MW)) err = 1'b1;
`endif
        idx      = int'((addr >> 2) % 32'(MW));
        w        = ref_mem[idx];
        new_word = w;
        rdata    = 32'h0;
        n_rd     = 0;
        n_wr     = 0;
        lat      = 2;
        if (err) return;
        if (!wr) begin
            n_rd = 1;
            sh   = (f3[0] ? int'(addr & 32'd2) : int'(addr & 32'd3)) * 8;
            case (f3)
                3'd0, 3'd4: begin
                    v = (w >> sh) & 32'hFF;
                    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                end
                3'd1, 3'd5: begin
                    v = (w >> sh) & 32'hFFFF;
                    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                end
                default: v = w;
            endcase
            rdata = v;
        end else begin
            n_wr = 1;
            if (f3 == 3'd2) begin
                new_word = wd;
            end else if (f3 == 3'd0) begin
                sh = int'(addr & 32'd3) * 8;
                new_word = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                n_rd = 1;
                lat  = 3;
            end else begin
                sh = int'(addr & 32'd2) * 8;
                new_word = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                n_rd = 1;
                lat  = 3;
            end
            ref_mem[idx] = new_word;
        end
    endtask

    // Issue one request (called at a falling edge) and check everything about it
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        bit          e_err;
        logic [31:0] e_rdata, e_word, waddr, wdat, r_data;
        int          e_lat, e_rd, e_wr, idx, lat, rd_c, wr_c, both_c, stray_c, guard;
        bit          got, r_err;
        model(wr, f3, addr, wd, e_err, e_rdata, e_lat, e_rd, e_wr, idx, e_word);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 1; rd_c = 0; wr_c = 0; both_c = 0; stray_c = 0; got = 0;
        waddr = 32'h0; wdat = 32'h0; r_err = 1'b0; r_data = 32'h0;
        while (lat <= 8) begin
            @(negedge clock);
            if (mem_read_enable) rd_c++;
            if (mem_write_enable) begin
                wr_c++;
                waddr = mem_address;
                wdat  = mem_write_data;
            end
            if (mem_read_enable && mem_write_enable) both_c++;
            if (!mem_read_enable && !mem_write_enable &&
                (mem_address != 32'h0 || mem_write_data != 32'h0)) stray_c++;
            if (resp_valid) begin
                got = 1; r_err = resp_error; r_data = resp_rdata;
                break;
            end
            lat++;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_error", 32'(r_err), 32'(e_err));
        check("resp_rdata", r_data, e_rdata);
        check("rd_enables", 32'(rd_c), 32'(e_rd));
        check("wr_enables", 32'(wr_c), 32'(e_wr));
        check("both_enables", 32'(both_c), 32'd0);
        check("idle_bus", 32'(stray_c), 32'd0);
        if (e_wr != 0) begin
            check("write_addr", waddr, 32'(idx));
            check("write_data", wdat, e_word);
        end
        @(negedge clock);
        check("post_resp", {30'd0, resp_valid, req_ready}, 32'd1);
        check("mem_word", mem[idx], ref_mem[idx]);
        $display("txn wr=%0d f3=%0d addr=%h wd=%h -> err=%0d rdata=%h lat=%0d",
                 wr, f3, addr, wd, r_err, r_data, lat);
    endtask

    function automatic logic [31:0] out_vec();
        return {24'd0, req_ready, resp_valid, resp_error, mem_read_enable,
                mem_write_enable, |resp_rdata, |mem_address, |mem_write_data};
    endfunction

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        wr;
        int          wr_seen, resp_seen, r;

        for (int i = 0; i < MW; i++) ref_mem[i] = word_pat(i);

        // Reset held for three cycles
        repeat (3) @(negedge clock);
        check("reset_outputs_during", out_vec(), 32'h80);
        reset = 1'b1;
        @(negedge clock);
        check("reset_outputs_after", out_vec(), 32'h80);

        // Directed sequence from the plan
        run_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);   // SW
        run_txn(1'b1, 3'd0, 32'h12, 32'h000000AA);   // SB -> DEAABEEF
        check("sb_result", mem[4], 32'hDEAABEEF);
        run_txn(1'b0, 3'd0, 32'h13, 32'h0);          // LB  -> FFFFFFDE
        run_txn(1'b0, 3'd4, 32'h13, 32'h0);          // LBU -> 000000DE
        run_txn(1'b0, 3'd1, 32'h10, 32'h0);          // LH  -> FFFFBEEF
        run_txn(1'b0, 3'd5, 32'h12, 32'h0);          // LHU -> 0000DEAA
        run_txn(1'b0, 3'd2, 32'h11, 32'h0);          // misaligned LW
        run_txn(1'b1, 3'd1, 32'h13, 32'h1234);       // misaligned SH
        run_txn(1'b0, 3'd3, 32'h10, 32'h0);          // illegal funct3
        run_txn(1'b0, 3'd2, 32'h1004, 32'h0);        // bounds / wrap

        // Reset during the read half of a sub-word store
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
        req_addr = 32'h20; req_wdata = 32'h0000CAFE;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rmw_rd_active", 32'(mem_read_enable), 32'd1);
        reset = 1'b0;
        wr_seen = 0; resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (mem_write_enable) wr_seen++;
            if (resp_valid) resp_seen++;
            if (c == 2) reset = 1'b1;
        end
        check("abort_no_write", 32'(wr_seen), 32'd0);
        check("abort_no_resp", 32'(resp_seen), 32'd0);
        check("abort_idle", out_vec(), 32'h80);
        check("abort_word8", mem[8], ref_mem[8]);
        $display("txn reset during RMW: writes=%0d resps=%0d", wr_seen, resp_seen);

        // Random traffic, mostly legal and aligned, some far-out addresses
        for (int t = 0; t < 300; t++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0) begin
                r  = $urandom_range(0, 4);
                f3 = wr ? 3'(r % 3) : ((r < 3) ? 3'(r) : 3'(r + 1));
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            r = $urandom_range(0, 9);
            if (r == 0)      addr = $urandom;
            else if (r < 6)  addr = 32'($urandom_range(0, 127));
            else             addr = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            run_txn(wr, f3, addr, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
